// File: rtl/packet_buffer_bypass_mslot.sv
// Multi-slot packet buffer: receives whole packets into RAM slots while earlier
// packets are sent downstream, decoding each packet's route word on the way out.
module packet_buffer_bypass_mslot #(
    parameter int DATA_W    = 64,
    parameter int ROUTE_W   = 24,
    parameter int LEN_W     = 8,
    parameter int NUM_SLOTS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [ROUTE_W-1:0] in_pkt_route,
    input  logic               in_wr,
    output logic               in_empty,
    input  logic               in_req,
    output logic               in_ack,
    output logic [DATA_W-1:0]  out_data,
    output logic [ROUTE_W-1:0] out_pkt_route,
    output logic               out_wr,
    output logic               out_req,
    input  logic               out_ack,
    output logic [1:0]         out_neighbor,
    output logic               out_bop,
    output logic               out_eop,
    input  logic               out_rdy,
    output logic               out_bypass,
    output logic               drop_pulse
);

    localparam int PTR_W  = $clog2(NUM_SLOTS);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DEPTH  = NUM_SLOTS * (2 ** LEN_W);
    localparam int ADDR_W = PTR_W + LEN_W;

    typedef enum logic {W_IDLE, W_RECV} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_SEND, R_CANCEL} rstate_t;

    // Write side state
    wstate_t              wstate_q, wstate_d;
    logic                 in_ack_q, in_ack_d;
    logic [LEN_W:0]       wlen_q, wlen_d;
    logic                 ovf_q, ovf_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic                 drop_q, drop_d;
    logic                 in_empty_q, in_empty_d;
    logic                 accept, commit, mem_we, route_we;

    // Shared slot bookkeeping
    logic [CNT_W-1:0]     used_q, used_d;
    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [LEN_W:0]       slot_len_q   [NUM_SLOTS];
    logic [ROUTE_W-1:0]   slot_route_q [NUM_SLOTS];
    logic [DATA_W-1:0]    mem_q        [DEPTH];
    logic                 have_free;

    // Read side state
    rstate_t              rstate_q, rstate_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LEN_W:0]       rlen_q, rlen_d;
    logic                 out_req_q, out_req_d;
    logic                 out_wr_q, out_wr_d;
    logic                 out_bop_q, out_bop_d;
    logic                 out_eop_q, out_eop_d;
    logic [DATA_W-1:0]    out_data_q;
    logic [ROUTE_W-1:0]   route_q;
    logic                 rd_fire, free_en, load_route;
    logic [LEN_W:0]       cur_len;
    logic                 unused_route;

    // Slots are used in FIFO order, so a free slot always sits at wr_ptr.
    assign have_free = (used_q != CNT_W'(NUM_SLOTS));
    assign cur_len   = slot_len_q[rd_ptr_q];

    always_comb begin
        wstate_d = wstate_q;
        in_ack_d = in_ack_q;
        wlen_d   = wlen_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        drop_d   = 1'b0;
        accept   = 1'b0;
        commit   = 1'b0;
        mem_we   = 1'b0;
        route_we = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (in_req && have_free) begin
                    wstate_d = W_RECV;
                    in_ack_d = 1'b1;
                    wlen_d   = '0;
                    ovf_d    = 1'b0;
                    accept   = 1'b1;
                end
            end
            W_RECV: begin
                if (!in_req) begin
                    wstate_d = W_IDLE;
                    in_ack_d = 1'b0;
                    if (wlen_q != '0 && !ovf_q) begin
                        commit   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (in_wr) begin
                    if (wlen_q[LEN_W]) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        route_we = (wlen_q == '0);
                        wlen_d   = wlen_q + (LEN_W+1)'(1);
                    end
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d   = rstate_q;
        rd_ptr_d   = rd_ptr_q;
        rlen_d     = rlen_q;
        out_req_d  = out_req_q;
        out_wr_d   = 1'b0;
        out_bop_d  = 1'b0;
        out_eop_d  = 1'b0;
        rd_fire    = 1'b0;
        free_en    = 1'b0;
        load_route = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (valid_q[rd_ptr_q]) begin
                    load_route = 1'b1;
                    rlen_d     = '0;
                    rstate_d   = R_REQ;
                end
            end
            R_REQ: begin
                out_req_d = 1'b1;
                // Only an ack seen while our request is visible counts as a grant.
                if (out_req_q && out_ack) begin
                    rstate_d = R_SEND;
                end
            end
            R_SEND: begin
                out_req_d = 1'b1;
                if (out_rdy && (rlen_q < cur_len)) begin
                    rd_fire   = 1'b1;
                    out_wr_d  = 1'b1;
                    out_bop_d = (rlen_q == '0);
                    out_eop_d = (rlen_q == cur_len - (LEN_W+1)'(1));
                    rlen_d    = rlen_q + (LEN_W+1)'(1);
                    if (out_eop_d) begin
                        out_req_d = 1'b0;
                        rstate_d  = R_CANCEL;
                    end
                end
            end
            R_CANCEL: begin
                out_req_d = 1'b0;
                if (!out_ack) begin
                    free_en  = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        if (commit) valid_d[wr_ptr_q] = 1'b1;
        if (free_en) valid_d[rd_ptr_q] = 1'b0;
        used_d = used_q + CNT_W'(accept) - CNT_W'(drop_d) - CNT_W'(free_en);
        in_empty_d = (wstate_d == W_IDLE) && (used_d != CNT_W'(NUM_SLOTS));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate_q   <= W_IDLE;
            in_ack_q   <= 1'b0;
            wlen_q     <= '0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            drop_q     <= 1'b0;
            in_empty_q <= 1'b0;
            used_q     <= '0;
            valid_q    <= '0;
            rstate_q   <= R_IDLE;
            rd_ptr_q   <= '0;
            rlen_q     <= '0;
            out_req_q  <= 1'b0;
            out_wr_q   <= 1'b0;
            out_bop_q  <= 1'b0;
            out_eop_q  <= 1'b0;
            route_q    <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_len_q[i]   <= '0;
                slot_route_q[i] <= '0;
            end
        end else begin
            wstate_q   <= wstate_d;
            in_ack_q   <= in_ack_d;
            wlen_q     <= wlen_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            drop_q     <= drop_d;
            in_empty_q <= in_empty_d;
            used_q     <= used_d;
            valid_q    <= valid_d;
            rstate_q   <= rstate_d;
            rd_ptr_q   <= rd_ptr_d;
            rlen_q     <= rlen_d;
            out_req_q  <= out_req_d;
            out_wr_q   <= out_wr_d;
            out_bop_q  <= out_bop_d;
            out_eop_q  <= out_eop_d;
            if (commit) slot_len_q[wr_ptr_q] <= wlen_q;
            if (route_we) slot_route_q[wr_ptr_q] <= in_pkt_route;
            if (load_route) route_q <= slot_route_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[ADDR_W'({wr_ptr_q, wlen_q[LEN_W-1:0]})] <= in_data;
    end

    // The RAM read register doubles as the out_data output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q <= '0;
        end else if (rd_fire) begin
            out_data_q <= mem_q[ADDR_W'({rd_ptr_q, rlen_q[LEN_W-1:0]})];
        end
    end

    assign in_ack        = in_ack_q;
    assign in_empty      = in_empty_q;
    assign drop_pulse    = drop_q;
    assign out_req       = out_req_q;
    assign out_wr        = out_wr_q;
    assign out_bop       = out_bop_q;
    assign out_eop       = out_eop_q;
    assign out_data      = out_data_q;
    assign out_neighbor  = route_q[1:0];
    assign out_bypass    = route_q[5];
    assign out_pkt_route = {3'b000, route_q[ROUTE_W-1:3]};
    assign unused_route  = route_q[2];

endmodule

// File: tb/tb_packet_buffer_bypass_mslot.sv
// Scoreboard bench for packet_buffer_bypass_mslot with small slots (8 words).
module tb_packet_buffer_bypass_mslot;

    localparam int DW   = 32;
    localparam int RW   = 24;
    localparam int LW   = 3;
    localparam int NS   = 2;
    localparam int MAXW = 1 << LW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [RW-1:0] in_pkt_route = '0;
    logic          in_wr = 1'b0;
    logic          in_req = 1'b0;
    logic          out_ack = 1'b0;
    logic          out_rdy = 1'b0;
    logic          in_empty, in_ack, out_wr, out_req, out_bop, out_eop, out_bypass, drop_pulse;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_pkt_route;
    logic [1:0]    out_neighbor;

    packet_buffer_bypass_mslot #(
        .DATA_W(DW), .ROUTE_W(RW), .LEN_W(LW), .NUM_SLOTS(NS)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_pkt_route(in_pkt_route), .in_wr(in_wr),
        .in_empty(in_empty), .in_req(in_req), .in_ack(in_ack),
        .out_data(out_data), .out_pkt_route(out_pkt_route), .out_wr(out_wr),
        .out_req(out_req), .out_ack(out_ack), .out_neighbor(out_neighbor),
        .out_bop(out_bop), .out_eop(out_eop), .out_rdy(out_rdy),
        .out_bypass(out_bypass), .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [DW-1:0] data; logic bop; logic eop;} word_t;
    typedef struct packed {logic [1:0] nb; logic byp; logic [RW-1:0] rt;} rte_t;

    word_t exp_q[$];
    rte_t  rte_q[$];

    int   vectors = 0, miscompares = 0;
    int   cyc = 0, words_out = 0, drop_cnt = 0, req_rises = 0, last_wr_cyc = -10;
    int   ack_delay = 0, ack_cnt = 0, rdy_mode = 0;
    logic prev_req = 1'b0, rdy_at_edge = 1'b0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rdy_at_edge <= out_rdy;
    end

    // Downstream arbiter and ready source
    always @(posedge clk) begin
        #1;
        if (reset || !out_req) begin
            out_ack = 1'b0;
            ack_cnt = 0;
        end else if (!out_ack) begin
            if (ack_cnt >= ack_delay) out_ack = 1'b1;
            else ack_cnt++;
        end
        out_rdy = (rdy_mode == 0) ? 1'b1 : ~out_rdy;
    end

    // Output monitor: pops expected words and routes as the DUT produces them
    always @(negedge clk) begin
        if (reset) begin
            prev_req = 1'b0;
        end else begin
            if (out_wr) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word: got data=%h bop=%b eop=%b, none expected", out_data, out_bop, out_eop);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    if ({out_data, out_bop, out_eop} !== {e.data, e.bop, e.eop}) begin
                        miscompares++;
                        $display("FAIL out_word: got data=%h bop=%b eop=%b, want data=%h bop=%b eop=%b",
                                 out_data, out_bop, out_eop, e.data, e.bop, e.eop);
                    end
                end
                if (rdy_mode == 1) begin
                    vectors++;
                    if (rdy_at_edge !== 1'b1) begin
                        miscompares++;
                        $display("FAIL wr_after_rdy: out_wr=1 with previous out_rdy=%b, want 1", rdy_at_edge);
                    end
                end else if (!out_bop) begin
                    vectors++;
                    if (cyc != last_wr_cyc + 1) begin
                        miscompares++;
                        $display("FAIL wr_gap: word at cycle %0d, previous at %0d, want consecutive", cyc, last_wr_cyc);
                    end
                end
                last_wr_cyc = cyc;
                words_out++;
            end
            if (out_req && !prev_req) begin
                req_rises++;
                vectors++;
                if (rte_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_req: out_req rose with no packet expected");
                end else begin
                    rte_t r;
                    r = rte_q.pop_front();
                    if ({out_neighbor, out_bypass, out_pkt_route} !== {r.nb, r.byp, r.rt}) begin
                        miscompares++;
                        $display("FAIL route: got nb=%0d byp=%b rt=%h, want nb=%0d byp=%b rt=%h",
                                 out_neighbor, out_bypass, out_pkt_route, r.nb, r.byp, r.rt);
                    end
                end
            end
            prev_req = out_req;
            if (drop_pulse) drop_cnt++;
        end
    end

    function automatic rte_t exp_route(input logic [RW-1:0] r);
        rte_t x;
        x.nb  = r[1:0];
        x.byp = r[5];
        x.rt  = r >> 3;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [RW-1:0] rt);
        in_pkt_route = rt;
        in_req       = 1'b1;
    endtask

    task automatic wait_ack(input int budget, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (in_ack !== 1'b1 && n < budget);
        vectors++;
        if (in_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_ack: in_ack=%b after %0d cycles, want 1", tag, in_ack, n);
        end
    endtask

    task automatic write_words(input int n, input logic [DW-1:0] base, input bit push);
        for (int i = 0; i < n; i++) begin
            in_wr   = 1'b1;
            in_data = base + DW'(i);
            if (push) exp_q.push_back({in_data, (i == 0), (i == n - 1)});
            tick();
        end
        in_wr = 1'b0;
    endtask

    task automatic end_req(input logic [RW-1:0] rt, input bit push);
        in_req = 1'b0;
        if (push) rte_q.push_back(exp_route(rt));
        tick();
        vectors++;
        if (in_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_drop: in_ack=%b after in_req fell, want 0", in_ack);
        end
    endtask

    task automatic send_pkt(input int n, input logic [RW-1:0] rt, input logic [DW-1:0] base,
                            input bit push, input string tag);
        start_req(rt);
        wait_ack(50, tag);
        write_words(n, base, push);
        end_req(rt, push);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(exp_q.size() == 0 && !out_req && !out_ack && !in_ack) && n < budget);
        vectors++;
        if (!(exp_q.size() == 0 && !out_req && !out_ack && !in_ack)) begin
            miscompares++;
            $display("FAIL %s_idle: %0d words pending, out_req=%b after %0d cycles", tag, exp_q.size(), out_req, n);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({in_empty, in_ack, out_wr, out_req, out_bop, out_eop, out_bypass, drop_pulse, out_neighbor} !== 10'b0
            || out_data !== '0 || out_pkt_route !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: empty=%b ack=%b wr=%b req=%b data=%h, want all 0",
                     in_empty, in_ack, out_wr, out_req, out_data);
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (in_empty !== 1'b1 || in_ack !== 1'b0 || out_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: in_empty=%b in_ack=%b out_req=%b, want 1 0 0", in_empty, in_ack, out_req);
        end
    endtask

    task automatic test_single();
        int   w0 = words_out;
        int   r0 = req_rises;
        rte_t r;
        rdy_mode  = 0;
        ack_delay = 2;
        start_req(24'h000025);
        wait_ack(20, "single");
        write_words(4, 32'hA000_0000, 1);
        r.nb = 2'd1; r.byp = 1'b1; r.rt = 24'h000004;
        rte_q.push_back(r);
        end_req(24'h000025, 0);
        wait_idle(100, "single");
        vectors++;
        if (words_out - w0 != 4 || req_rises - r0 != 1) begin
            miscompares++;
            $display("FAIL single_count: words=%0d reqs=%0d, want 4 1", words_out - w0, req_rises - r0);
        end
    endtask

    task automatic test_back_to_back();
        int w0 = words_out;
        bit bad = 0;
        ack_delay = 20;
        send_pkt(3, 24'h000041, 32'hB000_0000, 1, "b2b_a");
        start_req(24'h000122);
        wait_ack(10, "b2b_b");
        vectors++;
        if (words_out != w0) begin
            miscompares++;
            $display("FAIL b2b_concurrent: %0d words out before second accept, want 0", words_out - w0);
        end
        write_words(5, 32'hB100_0000, 1);
        end_req(24'h000122, 1);
        start_req(24'h0003E7);
        repeat (6) begin
            tick();
            if (in_ack !== 1'b0 || in_empty !== 1'b0) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL full_hold: in_ack=%b in_empty=%b with all slots full, want 0 0", in_ack, in_empty);
        end
        wait_ack(300, "b2b_c");
        vectors++;
        if (words_out - w0 != 3) begin
            miscompares++;
            $display("FAIL b2b_free_order: %0d words out when third accepted, want 3", words_out - w0);
        end
        write_words(2, 32'hB200_0000, 1);
        end_req(24'h0003E7, 1);
        wait_idle(600, "b2b");
        vectors++;
        if (words_out - w0 != 10) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d words, want 10", words_out - w0);
        end
    endtask

    task automatic test_rdy_toggle();
        int w0 = words_out;
        ack_delay = 0;
        rdy_mode  = 1;
        send_pkt(8, 24'h00004A, 32'hC000_0000, 1, "toggle");
        wait_idle(200, "toggle");
        rdy_mode = 0;
        vectors++;
        if (words_out - w0 != 8) begin
            miscompares++;
            $display("FAIL toggle_count: got %0d words, want 8", words_out - w0);
        end
    endtask

    task automatic test_overflow();
        int d0 = drop_cnt;
        int r0 = req_rises;
        int w0 = words_out;
        ack_delay = 0;
        send_pkt(MAXW + 1, 24'h0000FF, 32'hD000_0000, 0, "ovf");
        repeat (10) tick();
        vectors++;
        if (drop_cnt != d0 + 1 || req_rises != r0 || words_out != w0) begin
            miscompares++;
            $display("FAIL ovf_drop: drops=%0d reqs=%0d words=%0d, want 1 0 0", drop_cnt - d0, req_rises - r0, words_out - w0);
        end
        send_pkt(MAXW, 24'h000033, 32'hD100_0000, 1, "full_len");
        wait_idle(200, "full_len");
        vectors++;
        if (words_out - w0 != MAXW || drop_cnt != d0 + 1) begin
            miscompares++;
            $display("FAIL full_len: words=%0d drops=%0d, want %0d 1", words_out - w0, drop_cnt - d0, MAXW);
        end
    endtask

    task automatic test_empty_req();
        int d0 = drop_cnt;
        int w0 = words_out;
        bit bad = 0;
        ack_delay = 30;
        send_pkt(2, 24'h000011, 32'hE000_0000, 1, "empty_x");
        start_req(24'h000077);
        wait_ack(10, "empty");
        end_req(24'h000077, 0);
        tick();
        vectors++;
        if (drop_cnt != d0 + 1) begin
            miscompares++;
            $display("FAIL empty_drop: drops=%0d, want 1", drop_cnt - d0);
        end
        start_req(24'h000026);
        wait_ack(10, "empty_y");
        write_words(3, 32'hE100_0000, 1);
        end_req(24'h000026, 1);
        start_req(24'h000055);
        repeat (4) begin
            tick();
            if (in_ack !== 1'b0) bad = 1;
        end
        vectors++;
        if (bad || in_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_freecnt: in_ack seen=%b in_empty=%b with both slots used, want 0 0", bad, in_empty);
        end
        in_req = 1'b0;
        tick();
        wait_idle(400, "empty");
        vectors++;
        if (words_out - w0 != 5) begin
            miscompares++;
            $display("FAIL empty_count: got %0d words, want 5", words_out - w0);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        int n = 0;
        ack_delay = 0;
        rdy_mode  = 1;
        w0 = words_out;
        send_pkt(8, 24'h000020, 32'hF000_0000, 1, "mid_p");
        start_req(24'h000021);
        wait_ack(10, "mid_q");
        write_words(2, 32'hF100_0000, 0);
        in_req = 1'b1;
        while (words_out == w0 && n < 50) begin
            tick();
            n++;
        end
        reset = 1'b1;
        in_req = 1'b0;
        in_wr  = 1'b0;
        #1;
        vectors++;
        if ({in_empty, in_ack, out_wr, out_req, out_bop, out_eop, out_bypass, drop_pulse, out_neighbor} !== 10'b0
            || out_data !== '0 || out_pkt_route !== '0 || words_out == w0) begin
            miscompares++;
            $display("FAIL mid_reset: empty=%b ack=%b wr=%b req=%b data=%h started=%0d, want all 0 and started",
                     in_empty, in_ack, out_wr, out_req, out_data, words_out - w0);
        end
        exp_q.delete();
        rte_q.delete();
        rdy_mode = 0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (in_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_release: in_empty=%b, want 1", in_empty);
        end
        w0 = words_out;
        send_pkt(4, 24'h0000A6, 32'hF200_0000, 1, "mid_r");
        wait_idle(200, "mid_r");
        vectors++;
        if (words_out - w0 != 4) begin
            miscompares++;
            $display("FAIL mid_after: got %0d words, want 4", words_out - w0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_rdy_toggle();
        test_overflow();
        test_empty_req();
        test_reset_mid();
        vectors++;
        if (exp_q.size() != 0 || rte_q.size() != 0) begin
            miscompares++;
            $display("FAIL drained: %0d words %0d routes left, want 0 0", exp_q.size(), rte_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
